// File: rtl/seven_segment_scan.sv
// Multiplexed seven-segment driver: sequential double-dabble BCD conversion, atomic latch, timed anode scan.
// Optional leading-zero blanking under SEVSEG_LZB_EN.
module seven_segment_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int BIN_W       = 16,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BIN_W-1:0]      nums,
  output logic [6:0]            display,
  output logic [NUM_DIGITS-1:0] digit,
  output logic                  busy,
  output logic                  overflow
);

  localparam int BCD_D = (BIN_W * 301) / 1000 + 1;
  localparam int EXT_D = (BCD_D > NUM_DIGITS) ? BCD_D : NUM_DIGITS;
  localparam int EXT_W = 4 * EXT_D;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int TMR_W = $clog2(REFRESH_DIV);
  localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t                        r_state, w_state_nxt;
  logic [BIN_W-1:0]              r_shift;
  logic [4*BCD_D-1:0]            r_scratch;
  logic [CNT_W-1:0]              r_cnt;
  logic [NUM_DIGITS-1:0][3:0]    r_disp;
  logic                          r_overflow;
  logic [TMR_W-1:0]              r_timer;
  logic [SEL_W-1:0]              r_sel;
  logic [6:0]                    r_display;
  logic [NUM_DIGITS-1:0]         r_digit;

  logic [4*BCD_D-1:0]            w_adj;
  logic [EXT_W-1:0]              w_ext;
  logic [NUM_DIGITS-1:0][3:0]    w_latch;
  logic                          w_ovf;
  logic [NUM_DIGITS-1:0]         w_blank;
  logic [3:0]                    w_nib;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_cnt == CNT_W'(BIN_W - 1)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_adj = r_scratch;
    for (int i = 0; i < BCD_D; i++)
      if (r_scratch[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
  end

  // Nibbles beyond the displayed range decide saturation; scratch is zero-extended when narrower.
  assign w_ext = EXT_W'(r_scratch);

  always_comb begin
    w_ovf   = 1'b0;
    w_latch = '0;
    for (int i = 0; i < NUM_DIGITS; i++) w_latch[i] = w_ext[4*i +: 4];
    for (int i = NUM_DIGITS; i < EXT_D; i++)
      if (w_ext[4*i +: 4] != 4'd0) w_ovf = 1'b1;
    if (w_ovf) w_latch = {NUM_DIGITS{4'd9}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_disp     <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_shift   <= nums;
          r_scratch <= '0;
          r_cnt     <= '0;
        end
        S_SHIFT: begin
          r_scratch <= (w_adj << 1) | {{(4*BCD_D-1){1'b0}}, r_shift[BIN_W-1]};
          r_shift   <= r_shift << 1;
          r_cnt     <= r_cnt + CNT_W'(1);
        end
        S_DONE: begin
          r_disp     <= w_latch;
          r_overflow <= w_ovf;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
      r_sel   <= '0;
    end else if (r_timer == TMR_W'(REFRESH_DIV - 1)) begin
      r_timer <= '0;
      r_sel   <= (r_sel == SEL_W'(NUM_DIGITS - 1)) ? '0 : r_sel + SEL_W'(1);
    end else begin
      r_timer <= r_timer + TMR_W'(1);
    end
  end

`ifdef SEVSEG_LZB_EN
  always_comb begin
    logic w_run;
    w_run   = 1'b1;
    w_blank = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      w_run      = w_run & (r_disp[k] == 4'd0);
      w_blank[k] = w_run & ~r_overflow;
    end
  end
`else
  assign w_blank = '0;
`endif

  assign w_nib = r_disp[r_sel];

  // Segments and anodes share one register stage so they always switch on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_display <= 7'b1111111;
      r_digit   <= '1;
    end else begin
      r_display <= w_blank[r_sel] ? 7'b1111111 : seg_decode(w_nib);
      r_digit   <= ~(NUM_DIGITS'(1) << r_sel);
    end
  end

  assign display  = r_display;
  assign digit    = r_digit;
  assign busy     = (r_state != S_IDLE);
  assign overflow = r_overflow;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Randomized bench for seven_segment_scan against a decimal-arithmetic reference model.
module tb_seven_segment_scan;

  localparam int ND    = 4;
  localparam int BW    = 16;
  localparam int RD    = 4;
  localparam int PER   = BW + 2;
  localparam int LIMIT = 10 ** ND;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [BW-1:0] nums;
  logic [6:0]    display;
  logic [ND-1:0] digit;
  logic          busy;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  int         cyc;
  int         m_val;
  int         m_samp;
  logic [6:0] m_disp;
  logic [ND-1:0] m_dig;
  bit         chk_en = 1'b0;

  seven_segment_scan #(
    .NUM_DIGITS (ND),
    .BIN_W      (BW),
    .REFRESH_DIV(RD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .nums    (nums),
    .display (display),
    .digit   (digit),
    .busy    (busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected segments of decimal position k for a latched value v.
  function automatic logic [6:0] exp_seg(input int v, input int k);
    int p;
    int d;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    d = (v >= LIMIT) ? 9 : (v / p) % 10;
`ifdef SEVSEG_LZB_EN
    if (k > 0 && v < p && v < LIMIT) return 7'b1111111;
`endif
    return seg_of(d);
  endfunction

  // Reference timeline: sample every PER cycles starting at the first edge, latch PER-1 edges later,
  // anode position advances every RD edges.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc    = 0;
      m_val  = 0;
      m_samp = 0;
      m_disp = 7'b1111111;
      m_dig  = '1;
    end else begin
      m_dig  = ~(ND'(1) << ((cyc / RD) % ND));
      m_disp = exp_seg(m_val, (cyc / RD) % ND);
      if (cyc % PER == 0)       m_samp = int'(nums);
      if (cyc % PER == PER - 1) m_val  = m_samp;
      cyc = cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("display",  32'(display),  32'(m_disp));
      chk("digit",    32'(digit),    32'(m_dig));
      chk("busy",     32'(busy),     32'((cyc % PER) != 0));
      chk("overflow", 32'(overflow), 32'(m_val >= LIMIT));
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_phase(input int ph);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 3 * PER && !hit; i++) begin
      @(negedge clk);
      if (cyc % PER == ph) hit = 1'b1;
    end
    chk("phase_sync", 32'(hit), 32'd1);
  endtask

  initial begin
    rst_n  = 1'b0;
    nums   = '0;
    chk_en = 1'b1;
    run(3);
    rst_n = 1'b1;
    run(2 * PER);

    nums = BW'(1234);  run(3 * PER);
    nums = BW'(12345); run(3 * PER);
    nums = BW'(9999);  run(3 * PER);
    nums = BW'(7);     run(3 * PER);
    nums = BW'(10000); run(3 * PER);
    nums = BW'(65535); run(3 * PER);

    nums = BW'(500);
    wait_phase(3);
    nums = BW'(600);
    run(3 * PER);

    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 3))
        0: nums = BW'($urandom_range(0, 9));
        1: nums = BW'($urandom_range(0, LIMIT - 1));
        2: nums = BW'($urandom_range(LIMIT, (1 << BW) - 1));
        default: nums = BW'($urandom);
      endcase
      run($urandom_range(1, 30));
    end

    nums = BW'(4321);
    wait_phase(PER - 1);
    run(2);
    wait_phase(6);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_display",  32'(display),  32'h7f);
    chk("rst_digit",    32'(digit),    32'(ND'('1)));
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    run(2);
    rst_n = 1'b1;
    run(3 * PER);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
